// File: rtl/bp_be_loop_inference_sched_pkg.sv
// Shared types for the backend loop-inference scheduler.
package bp_be_loop_inference_sched_pkg;

   typedef enum logic [2:0] {
      e_li_idle   = 3'd0,
      e_li_start  = 3'd1,
      e_li_search = 3'd2,
      e_li_abort  = 3'd3,
      e_li_resp   = 3'd4
   } bp_be_li_sched_state_e;

endpackage

// File: rtl/bp_be_loop_inference_sched_if.sv
// Requester, loop-inference-unit and response signals of the scheduler.
interface bp_be_loop_inference_sched_if #(
   parameter int num_req_p      = 4,
   parameter int vaddr_width_p  = 39,
   parameter int output_range_p = 8
);
   localparam int id_width_lp = $clog2(num_req_p);

   logic [num_req_p-1:0]               req_v_i;
   logic [num_req_p*vaddr_width_p-1:0] req_pc_i;
   logic [num_req_p-1:0]               req_confirm_i;
   logic [num_req_p-1:0]               grant_o;
   logic                               start_discovery_o;
   logic                               confirm_discovery_o;
   logic [vaddr_width_p-1:0]           striding_pc_o;
   logic                               abort_o;
   logic                               li_v_i;
   logic [output_range_p-1:0]          li_iters_i;
   logic                               li_yumi_o;
   logic                               resp_v_o;
   logic [id_width_lp-1:0]             resp_id_o;
   logic [output_range_p-1:0]          resp_iters_o;
   logic                               resp_timeout_o;
   logic                               resp_ready_i;
   logic                               busy_o;

   modport slave (
      input  req_v_i, req_pc_i, req_confirm_i, li_v_i, li_iters_i, resp_ready_i,
      output grant_o, start_discovery_o, confirm_discovery_o, striding_pc_o, abort_o,
             li_yumi_o, resp_v_o, resp_id_o, resp_iters_o, resp_timeout_o, busy_o
   );

   modport master (
      output req_v_i, req_pc_i, req_confirm_i, li_v_i, li_iters_i, resp_ready_i,
      input  grant_o, start_discovery_o, confirm_discovery_o, striding_pc_o, abort_o,
             li_yumi_o, resp_v_o, resp_id_o, resp_iters_o, resp_timeout_o, busy_o
   );
endinterface

// File: rtl/bp_be_loop_inference_sched_arb.sv
// Round-robin arbiter; the priority pointer moves past the winner when the grant is taken.
module bp_be_loop_inference_sched_arb #(
   parameter int width_p = 4,
   localparam int tag_width_lp = $clog2(width_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [width_p-1:0]      reqs_i,
   input  logic                    yumi_i,
   output logic [width_p-1:0]      grants_o,
   output logic [tag_width_lp-1:0] tag_o,
   output logic                    v_o
);
   logic [tag_width_lp-1:0] ptr_r;
   int                      idx;

   always_comb begin
      grants_o = '0;
      tag_o    = '0;
      v_o      = 1'b0;
      idx      = 0;
      for (int i = 0; i < width_p; i++) begin
         idx = (int'(ptr_r) + i) % width_p;
         if (!v_o && reqs_i[idx]) begin
            v_o           = 1'b1;
            tag_o         = tag_width_lp'(idx);
            grants_o[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         ptr_r <= '0;
      else if (yumi_i && v_o)
         ptr_r <= (int'(tag_o) == width_p-1) ? '0 : tag_o + 1'b1;
   end
endmodule

// File: rtl/bp_be_loop_inference_sched.sv
// Time-shares the single loop-inference unit across the striding-load detectors.
//
// state  | meaning
// IDLE   | waiting for any requester; arbitrate and latch owner/PC
// START  | one-cycle start pulse to the unit, timer cleared
// SEARCH | unit running; watch result, owner withdrawal and timeout
// ABORT  | one-cycle abort pulse; discard or report the timeout default
// RESP   | response held until accepted
module bp_be_loop_inference_sched
   import bp_be_loop_inference_sched_pkg::*;
#(
   parameter int num_req_p        = 4,
   parameter int vaddr_width_p    = 39,
   parameter int output_range_p   = 8,
   parameter int timeout_cycles_p = 256,
   parameter int default_iters_p  = 128
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   bp_be_loop_inference_sched_if.slave io
);
   localparam int id_width_lp    = $clog2(num_req_p);
   localparam int timer_width_lp = $clog2(timeout_cycles_p) + 1;
   localparam logic [timer_width_lp-1:0] timer_last_lp  = timer_width_lp'(timeout_cycles_p - 1);
   localparam logic [output_range_p-1:0] default_iters_lp = output_range_p'(default_iters_p);

   typedef struct packed {
      logic [id_width_lp-1:0]    id;
      logic [output_range_p-1:0] iters;
      logic                      timeout;
   } bp_be_li_resp_s;

   bp_be_li_sched_state_e       state_r, state_n;
   bp_be_li_resp_s              resp_r;
   logic [vaddr_width_p-1:0]    pc_r;
   logic [timer_width_lp-1:0]   timer_r;
   logic                        discard_r;

   logic [num_req_p-1:0]        arb_grants;
   logic [id_width_lp-1:0]      arb_tag;
   logic                        arb_v;
   logic                        arb_yumi;
   logic                        owner_req;

   bp_be_loop_inference_sched_arb #(.width_p(num_req_p)) arb (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .reqs_i   (io.req_v_i),
      .yumi_i   (arb_yumi),
      .grants_o (arb_grants),
      .tag_o    (arb_tag),
      .v_o      (arb_v)
   );

   assign owner_req = io.req_v_i[resp_r.id];

   always_comb begin
      state_n        = state_r;
      arb_yumi       = 1'b0;
      io.li_yumi_o   = 1'b0;
      unique case (state_r)
         e_li_idle:   if (arb_v) begin
                         arb_yumi = 1'b1;
                         state_n  = e_li_start;
                      end
         e_li_start:  state_n = e_li_search;
         e_li_search: begin
            if (io.li_v_i) begin
               // the unit's result is always consumed, even if nobody is left to hear it
               io.li_yumi_o = 1'b1;
               state_n      = owner_req ? e_li_resp : e_li_idle;
            end else if (!owner_req || timer_r == timer_last_lp) begin
               state_n = e_li_abort;
            end
         end
         e_li_abort:  state_n = discard_r ? e_li_idle : e_li_resp;
         e_li_resp:   if (io.resp_ready_i) state_n = e_li_idle;
         default:     state_n = e_li_idle;
      endcase
   end

   always_comb begin
      io.grant_o = '0;
      if (state_r != e_li_idle) io.grant_o[resp_r.id] = 1'b1;
   end

   assign io.start_discovery_o   = (state_r == e_li_start);
   assign io.confirm_discovery_o = (state_r == e_li_search) && io.req_confirm_i[resp_r.id];
   assign io.striding_pc_o       = pc_r;
   assign io.abort_o             = (state_r == e_li_abort);
   assign io.resp_v_o            = (state_r == e_li_resp);
   assign io.resp_id_o           = resp_r.id;
   assign io.resp_iters_o        = resp_r.iters;
   assign io.resp_timeout_o      = resp_r.timeout;
   assign io.busy_o              = (state_r != e_li_idle);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r   <= e_li_idle;
         resp_r    <= '0;
         pc_r      <= '0;
         timer_r   <= '0;
         discard_r <= 1'b0;
      end else begin
         state_r <= state_n;
         case (state_r)
            e_li_idle: if (arb_v) begin
               resp_r.id <= arb_tag;
               pc_r      <= io.req_pc_i[int'(arb_tag)*vaddr_width_p +: vaddr_width_p];
               discard_r <= 1'b0;
            end
            e_li_start: timer_r <= '0;
            e_li_search: begin
               if (timer_r != '1) timer_r <= timer_r + 1'b1;
               if (io.li_v_i) begin
                  resp_r.iters   <= io.li_iters_i;
                  resp_r.timeout <= 1'b0;
               end else if (!owner_req) begin
                  discard_r <= 1'b1;
               end
            end
            e_li_abort: if (!discard_r) begin
               resp_r.iters   <= default_iters_lp;
               resp_r.timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   logic unused_grants;
   assign unused_grants = ^arb_grants;
endmodule

// File: tb/tb_bp_be_loop_inference_sched.sv
// Directed bench for the loop-inference scheduler with hand-computed expectations.
module tb_bp_be_loop_inference_sched;
   localparam int N  = 4;
   localparam int VA = 39;
   localparam int OR = 8;
   localparam int T  = 256;

   logic clk_i = 1'b0;
   logic reset_i;
   int   total = 0;
   int   bad   = 0;

   always #5 clk_i = ~clk_i;

   bp_be_loop_inference_sched_if #(.num_req_p(N), .vaddr_width_p(VA), .output_range_p(OR)) bus ();

   bp_be_loop_inference_sched #(
      .num_req_p(N), .vaddr_width_p(VA), .output_range_p(OR),
      .timeout_cycles_p(T), .default_iters_p(128)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .io      (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_v_i       = '0;
      bus.req_pc_i      = '0;
      bus.req_confirm_i = '0;
      bus.li_v_i        = 1'b0;
      bus.li_iters_i    = '0;
      bus.resp_ready_i  = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_i = 1'b1;
      #2;
      reset_i = 1'b0;
   endtask

   int early;
   int seen;
   logic [OR-1:0] k_iters;

   initial begin
      clear_inputs();
      reset_i = 1'b1;
      #3;
      chk("rst_busy",  bus.busy_o, 0);
      chk("rst_grant", bus.grant_o, 0);
      chk("rst_resp_v", bus.resp_v_o, 0);
      chk("rst_start", bus.start_discovery_o, 0);
      chk("rst_abort", bus.abort_o, 0);
      chk("rst_pc",    bus.striding_pc_o, 0);
      #4;
      reset_i = 1'b0;

      // single request from requester 1
      tick();
      bus.req_v_i = 4'b0010;
      bus.req_pc_i[1*VA +: VA] = 39'h80000040;
      tick();
      chk("single_grant", bus.grant_o, 4'b0010);
      chk("single_start", bus.start_discovery_o, 1);
      chk("single_pc",    bus.striding_pc_o, 39'h80000040);
      chk("single_busy",  bus.busy_o, 1);
      tick();
      chk("search_start_low", bus.start_discovery_o, 0);
      chk("confirm_idle", bus.confirm_discovery_o, 0);
      bus.req_confirm_i = 4'b0010;
      settle();
      chk("confirm_owner", bus.confirm_discovery_o, 1);
      bus.req_confirm_i = 4'b1101;
      settle();
      chk("confirm_nonowner", bus.confirm_discovery_o, 0);
      bus.req_confirm_i = '0;
      repeat (4) tick();
      bus.li_v_i     = 1'b1;
      bus.li_iters_i = 8'd37;
      settle();
      chk("single_yumi", bus.li_yumi_o, 1);
      tick();
      bus.li_v_i = 1'b0;
      chk("single_resp_v",  bus.resp_v_o, 1);
      chk("single_resp_id", bus.resp_id_o, 1);
      chk("single_iters",   bus.resp_iters_o, 37);
      chk("single_timeout", bus.resp_timeout_o, 0);
      chk("resp_grant_held", bus.grant_o, 4'b0010);
      bus.li_v_i = 1'b1;
      settle();
      chk("yumi_outside_search", bus.li_yumi_o, 0);
      bus.li_v_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_resp_v",  bus.resp_v_o, 1);
         chk("stall_iters",   bus.resp_iters_o, 37);
         chk("stall_id",      bus.resp_id_o, 1);
      end
      bus.resp_ready_i = 1'b1;
      tick();
      bus.resp_ready_i = 1'b0;
      bus.req_v_i      = '0;
      chk("single_done_busy",  bus.busy_o, 0);
      chk("single_done_grant", bus.grant_o, 0);

      // round robin with all requesting, from a fresh pointer
      do_reset();
      bus.req_v_i = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         seen = 0;
         for (int c = 0; c < 10 && seen == 0; c++) begin
            tick();
            if (bus.start_discovery_o) seen = 1;
         end
         chk("rr_start_seen", seen, 1);
         chk("rr_grant", bus.grant_o, 4'b0001 << (k % 4));
         tick();
         k_iters = 8'(k + 10);
         bus.li_v_i     = 1'b1;
         bus.li_iters_i = k_iters;
         tick();
         bus.li_v_i       = 1'b0;
         chk("rr_resp_id", bus.resp_id_o, k % 4);
         chk("rr_iters",   bus.resp_iters_o, k + 10);
         bus.resp_ready_i = 1'b1;
         tick();
         bus.resp_ready_i = 1'b0;
      end
      bus.req_v_i = '0;

      // timeout path
      do_reset();
      bus.req_v_i = 4'b0001;
      tick();
      chk("to_start", bus.start_discovery_o, 1);
      early = 0;
      for (int i = 1; i <= T; i++) begin
         tick();
         if (bus.abort_o) early++;
      end
      chk("to_no_early_abort", early, 0);
      chk("to_still_busy", bus.busy_o, 1);
      tick();
      chk("to_abort", bus.abort_o, 1);
      tick();
      chk("to_abort_one_cycle", bus.abort_o, 0);
      chk("to_resp_v",   bus.resp_v_o, 1);
      chk("to_iters",    bus.resp_iters_o, 128);
      chk("to_timeout",  bus.resp_timeout_o, 1);
      chk("to_id",       bus.resp_id_o, 0);
      bus.resp_ready_i = 1'b1;
      tick();
      bus.resp_ready_i = 1'b0;
      bus.req_v_i = '0;
      chk("to_idle", bus.busy_o, 0);

      // owner withdraws at search cycle 10
      do_reset();
      bus.req_v_i = 4'b0100;
      tick();
      tick();
      repeat (9) tick();
      bus.req_v_i = '0;
      tick();
      chk("wd_abort", bus.abort_o, 1);
      tick();
      chk("wd_idle",   bus.busy_o, 0);
      chk("wd_no_resp", bus.resp_v_o, 0);
      chk("wd_abort_low", bus.abort_o, 0);
      bus.req_v_i = 4'b1111;
      tick();
      chk("wd_ptr_advanced", bus.grant_o, 4'b1000);

      // result arrives on the timeout cycle
      do_reset();
      bus.req_v_i = 4'b0001;
      tick();
      repeat (T) tick();
      bus.li_v_i     = 1'b1;
      bus.li_iters_i = 8'd99;
      settle();
      chk("col_yumi", bus.li_yumi_o, 1);
      tick();
      bus.li_v_i = 1'b0;
      chk("col_no_abort", bus.abort_o, 0);
      chk("col_resp_v",   bus.resp_v_o, 1);
      chk("col_timeout",  bus.resp_timeout_o, 0);
      chk("col_iters",    bus.resp_iters_o, 99);
      bus.resp_ready_i = 1'b1;
      tick();
      bus.resp_ready_i = 1'b0;
      bus.req_v_i = '0;

      // result coincides with owner withdrawal: consumed and dropped
      do_reset();
      bus.req_v_i = 4'b0001;
      tick();
      tick();
      bus.req_v_i    = '0;
      bus.li_v_i     = 1'b1;
      bus.li_iters_i = 8'd5;
      settle();
      chk("drop_yumi", bus.li_yumi_o, 1);
      tick();
      bus.li_v_i = 1'b0;
      chk("drop_idle",     bus.busy_o, 0);
      chk("drop_no_abort", bus.abort_o, 0);
      chk("drop_no_resp",  bus.resp_v_o, 0);

      // asynchronous reset mid-search
      do_reset();
      bus.req_v_i = 4'b0010;
      tick();
      tick();
      chk("ar_busy_before", bus.busy_o, 1);
      #2;
      reset_i = 1'b1;
      #1;
      chk("ar_busy",   bus.busy_o, 0);
      chk("ar_grant",  bus.grant_o, 0);
      chk("ar_resp_v", bus.resp_v_o, 0);
      chk("ar_abort",  bus.abort_o, 0);
      clear_inputs();
      #2;
      reset_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule

// File: doc/bp_be_loop_inference_sched.md
Name: bp_be_loop_inference_sched

Overview:
- Schedules the single backend loop-inference unit across `num_req_p` striding-load detectors.
- Round-robin grants the unit to one requester, issues the start-discovery pulse with that requester's PC, and forwards that requester's confirm.
- Bounds each search with a timeout and returns the iteration estimate, or a timeout default, to the owning requester over a valid/ready response port.
- Sits in `bp_be_checker` between the stride detectors and the loop-inference unit.

Parameters:
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `vaddr_width_p`.
- `num_req_p`, 4: number of striding-load requesters; must be ≥2.
- `output_range_p`, 8: width of the iteration estimate.
- `timeout_cycles_p`, 256: maximum SEARCH cycles before abort.
- `default_iters_p`, 128: iteration value reported on timeout.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; asynchronous, active-high.
- `req_v_i`  in  `num_req_p`  per-requester discovery request (level, held until served).
- `req_pc_i`  in  `num_req_p*vaddr_width_p`  per-requester striding-load PC.
- `req_confirm_i`  in  `num_req_p`  per-requester stride-confirmed level.
- `grant_o`  out  `num_req_p`  one-hot owner vector; all-zero in IDLE.
- `start_discovery_o`  out  1  one-cycle start pulse to the unit.
- `confirm_discovery_o`  out  1  owner's confirm, gated to SEARCH.
- `striding_pc_o`  out  `vaddr_width_p`  latched owner PC.
- `abort_o`  out  1  one-cycle pulse; integration ORs it into the unit's reset.
- `li_v_i`  in  1  unit result valid.
- `li_iters_i`  in  `output_range_p`  unit result.
- `li_yumi_o`  out  1  result consumed.
- `resp_v_o`  out  1  response valid.
- `resp_id_o`  out  `$clog2(num_req_p)`  owning requester index.
- `resp_iters_o`  out  `output_range_p`  iteration estimate.
- `resp_timeout_o`  out  1  response is the timeout default.
- `resp_ready_i`  in  1  response accepted.
- `busy_o`  out  1  state ≠ IDLE.

Behaviour:
Reset (asynchronous):
- State = IDLE; round-robin pointer = 0; owner, timer, PC and iters regs cleared.
- All outputs 0.

State machine, states IDLE, START, SEARCH, ABORT, RESP:
- IDLE:
  - If any `req_v_i`, the arbiter picks a winner, starting from the priority pointer.
  - Latch owner id and `req_pc_i[owner]`, then go to START.
  - `grant_o` rises in START, one cycle after the request is seen.
- START:
  - `start_discovery_o`=1 with `striding_pc_o` valid.
  - Timer cleared, then go to SEARCH.
- SEARCH:
  - `confirm_discovery_o` = `req_confirm_i[owner]`.
  - Timer increments each cycle.
  - Priority within a cycle, highest first:
    1. `li_v_i`=1: assert `li_yumi_o` combinationally the same cycle; latch `li_iters_i`; `timeout`=0; go to RESP. If `req_v_i[owner]`=0 in that same cycle, still yumi, discard the result, go to IDLE.
    2. `req_v_i[owner]`=0 (owner withdrew): go to ABORT with a discard flag set.
    3. Timer == `timeout_cycles_p`-1: go to ABORT.
- ABORT:
  - `abort_o`=1 for exactly one cycle.
  - If the discard flag is set, go to IDLE.
  - Otherwise: iters = `default_iters_p` truncated to `output_range_p` bits; `timeout`=1; go to RESP.
- RESP:
  - `resp_v_o`=1; `resp_id_o`, `resp_iters_o`, `resp_timeout_o` held stable until `resp_ready_i`.
  - On the handshake cycle: go to IDLE; pointer = owner+1 mod `num_req_p`.
  - `grant_o` stays asserted through RESP.

Other rules:
- `li_v_i` outside SEARCH: ignored, `li_yumi_o`=0.
- Requester inputs for non-owners are ignored while busy.
- The pointer also advances past the owner on an abort/discard path.
- `reset_i` mid-operation returns to IDLE immediately. No response is emitted and no abort pulse is issued; the unit shares the system reset.
- Timer width: `$clog2(timeout_cycles_p)+1`; it saturates and never wraps.
- Timeout latency: START at cycle 0 → ABORT at cycle `timeout_cycles_p`+1.

Decomposition:
- Shared package (`bp_be_pkg`):
  - `bp_be_li_sched_state_e` enum (IDLE, START, SEARCH, ABORT, RESP).
  - Response struct `bp_be_li_resp_s` {id, iters, timeout}.
- One sub-module instance: `bsg_arb_round_robin` (`width_p` = `num_req_p`) for winner selection.
  - Its yumi input is driven by the IDLE→START transition.

Test Plan:
- Reset: assert `reset_i` asynchronously mid-SEARCH → `busy_o`=0, `grant_o`=0, `resp_v_o`=0 with no clock edge required.
- Single request:
  - Stimulus: `req_v_i`=4'b0010, `pc`=0x8000_0040; `li_v_i`=1 with iters=37 at SEARCH cycle 5.
  - Response: `start_discovery_o` pulses with `striding_pc_o`=0x8000_0040; yumi occurs the same cycle; `resp_v_o`=1, id=1, iters=37, `timeout`=0.
  - Stall `resp_ready_i` for 3 cycles → response held stable.
- Round-robin: `req_v_i`=4'b1111 held, each search served → grant order 0,1,2,3,0.
- Timeout: no `li_v_i` for 256 cycles → one-cycle `abort_o`, then response iters=128, `timeout`=1.
- Withdraw and collisions:
  - Owner drops `req_v_i` at SEARCH cycle 10 → `abort_o` pulse, no response, IDLE.
  - `li_v_i` coincident with the timeout cycle → result taken, `timeout`=0, no abort.
- Confirm passthrough: owner `req_confirm_i`=1 during SEARCH → `confirm_discovery_o`=1. Non-owner confirm → `confirm_discovery_o`=0.
